// File: rtl/histogram_compressor.sv
// Bins a paired bitstream (a,b) into four counters over one fixed-length frame, then holds the
// resulting histogram until downstream takes it. abort wins over every other input.
module histogram_compressor #(
  parameter int unsigned StreamLength = 128,
  parameter int unsigned CounterWidth = $clog2(StreamLength + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_compress_i,
  input  logic                    abort_i,
  input  logic                    stream_a_i,
  input  logic                    stream_b_i,
  input  logic                    valid_in_i,
  output logic                    ready_in_o,
  output logic [CounterWidth-1:0] count_00_o,
  output logic [CounterWidth-1:0] count_01_o,
  output logic [CounterWidth-1:0] count_10_o,
  output logic [CounterWidth-1:0] count_11_o,
  output logic                    hist_valid_o,
  input  logic                    hist_ready_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

  localparam logic [CounterWidth-1:0] LastSample = CounterWidth'(StreamLength - 1);
  localparam logic [CounterWidth-1:0] One        = CounterWidth'(1);

  state_e                  state_q, state_d;
  logic [CounterWidth-1:0] bin_q [4];
  logic [CounterWidth-1:0] bin_d [4];
  logic [CounterWidth-1:0] sample_q, sample_d;
  logic                    ready_q, hist_valid_q, busy_q;
  logic                    clear;
  logic [1:0]              bin_idx;

  assign bin_idx = {stream_a_i, stream_b_i};

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    sample_d = sample_q;
    clear    = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_compress_i) begin
            state_d = StCollect;
            clear   = 1'b1;
          end
        end
        StCollect: begin
          if (valid_in_i) begin
            bin_d[bin_idx] = bin_q[bin_idx] + One;
            sample_d       = sample_q + One;
            if (sample_q == LastSample) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          // A release paired with a start chains straight into the next frame.
          if (hist_ready_i) begin
            if (start_compress_i) begin
              state_d = StCollect;
              clear   = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (clear) begin
      for (int i = 0; i < 4; i++) begin
        bin_d[i] = '0;
      end
      sample_d = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      ready_q      <= 1'b0;
      hist_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bin_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      ready_q      <= (state_d == StCollect);
      hist_valid_q <= (state_d == StHold);
      busy_q       <= (state_d != StIdle);
      for (int i = 0; i < 4; i++) begin
        bin_q[i] <= bin_d[i];
      end
    end
  end

  assign ready_in_o   = ready_q;
  assign hist_valid_o = hist_valid_q;
  assign busy_o       = busy_q;
  assign count_00_o   = bin_q[0];
  assign count_01_o   = bin_q[1];
  assign count_10_o   = bin_q[2];
  assign count_11_o   = bin_q[3];

endmodule
